// File: rtl/aphelion_pkg.sv
// Aphelion instruction-set constants shared by the encoder and decoder:
// instruction type codes and the immediate field width of each type.
package aphelion_pkg;

  // Type codes as they appear on the instr_type field (shared with the decoder)
  localparam logic [2:0] INSTR_TYPE_E       = 3'd0;
  localparam logic [2:0] INSTR_TYPE_R       = 3'd1;
  localparam logic [2:0] INSTR_TYPE_M       = 3'd2;
  localparam logic [2:0] INSTR_TYPE_I       = 3'd3;
  localparam logic [2:0] INSTR_TYPE_F       = 3'd4;
  localparam logic [2:0] INSTR_TYPE_B       = 3'd5;
  localparam logic [2:0] INSTR_TYPE_U       = 3'd6;
  localparam logic [2:0] INSTR_TYPE_ILLEGAL = 3'd7;

  // Immediate field widths in bits, per type
  localparam int IMM_W_E = 8;
  localparam int IMM_W_R = 12;
  localparam int IMM_W_M = 12;
  localparam int IMM_W_I = 16;
  localparam int IMM_W_F = 16;
  localparam int IMM_W_B = 20;
  localparam int IMM_W_U = 24;

  // Width of the immediate field for a type; the illegal code reports the
  // full 24 bits so it can never be flagged as an overflow.
  function automatic int imm_width(input logic [2:0] t);
    case (t)
      INSTR_TYPE_E: return IMM_W_E;
      INSTR_TYPE_R: return IMM_W_R;
      INSTR_TYPE_M: return IMM_W_M;
      INSTR_TYPE_I: return IMM_W_I;
      INSTR_TYPE_F: return IMM_W_F;
      INSTR_TYPE_B: return IMM_W_B;
      default:      return IMM_W_U;
    endcase
  endfunction

  // Mask of the imm bits that fit in the field for a type
  function automatic logic [23:0] imm_field_mask(input logic [2:0] t);
    logic [31:0] ones;
    ones = (32'd1 << imm_width(t)) - 32'd1;
    return ones[23:0];
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns a decoded Aphelion field bundle into a
// 32-bit instruction word and flags an illegal type code.
// Optional feature macro: ENCODER_IMM_CHECK_EN -- when defined, imm_ovf
// reports immediates that do not fit the type's field; otherwise it is 0.
module instr_pack
  import aphelion_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [2:0]  instr_type,
  input  logic [3:0]  rde,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  func,
  input  logic [23:0] imm,
  output logic [31:0] word,
  output logic        type_illegal,
  output logic        imm_ovf
);

  // Place each field at its per-type bit position; unused bits stay zero
  always_comb begin
    word         = 32'd0;
    word[7:0]    = opcode;
    type_illegal = 1'b0;
    case (instr_type)
      INSTR_TYPE_E: begin
        word[15:8]  = imm[7:0];
        word[19:16] = func;
        word[23:20] = rs2;
        word[27:24] = rs1;
        word[31:28] = rde;
      end
      INSTR_TYPE_R: begin
        word[19:8]  = imm[11:0];
        word[23:20] = rs2;
        word[27:24] = rs1;
        word[31:28] = rde;
      end
      INSTR_TYPE_M: begin
        word[19:8]  = imm[11:0];
        word[23:20] = func;
        word[27:24] = rs1;
        word[31:28] = rde;
      end
      INSTR_TYPE_I: begin
        word[23:8]  = imm[15:0];
        word[27:24] = rs1;
        word[31:28] = rde;
      end
      INSTR_TYPE_F: begin
        word[23:8]  = imm[15:0];
        word[27:24] = func;
        word[31:28] = rde;
      end
      INSTR_TYPE_B: begin
        word[27:8]  = imm[19:0];
        word[31:28] = func;
      end
      INSTR_TYPE_U: begin
        word[31:8]  = imm[23:0];
      end
      default: begin
        // Illegal code: the word is never pushed, only the flag matters
        type_illegal = 1'b1;
      end
    endcase
  end

`ifdef ENCODER_IMM_CHECK_EN
  // Any imm bit above the field width is lost by truncation
  assign imm_ovf = (|(imm & ~imm_field_mask(instr_type))) & ~type_illegal;
`else
  // Truncation is silent in this build
  assign imm_ovf = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming Aphelion instruction encoder. Packs field bundles into 32-bit
// words, queues them in a 2-entry output FIFO (head + tail register) and
// tags each word with a wrapping word address.
// Optional feature macro: ENCODER_IMM_CHECK_EN (sticky err_imm on imm
// overflow); when undefined err_imm stays 0.
module instr_encoder
  import aphelion_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2    // only 2 is supported by the head/tail structure
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        opcode,
  input  logic [2:0]        instr_type,
  input  logic [3:0]        rde,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [3:0]        func,
  input  logic [23:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_type,
  output logic              err_imm
);

  localparam logic [1:0]        DEPTH_C  = 2'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Head entry drives the outputs directly; tail holds the second word
  logic [31:0]       head_word_q, head_word_d;
  logic [ADDR_W-1:0] head_addr_q, head_addr_d;
  logic              head_valid_q, head_valid_d;
  logic [31:0]       tail_word_q, tail_word_d;
  logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
  logic              tail_valid_q, tail_valid_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              err_type_q, err_type_d;
  logic              err_imm_q, err_imm_d;

  logic [31:0] packed_word;
  logic        type_illegal;
  logic        imm_ovf;
  logic [1:0]  count;
  logic        accept;
  logic        push;
  logic        pop;

  instr_pack u_pack (
    .opcode       (opcode),
    .instr_type   (instr_type),
    .rde          (rde),
    .rs1          (rs1),
    .rs2          (rs2),
    .func         (func),
    .imm          (imm),
    .word         (packed_word),
    .type_illegal (type_illegal),
    .imm_ovf      (imm_ovf)
  );

  // Occupancy comes only from registered state so in_ready has no input path
  assign count    = {1'b0, head_valid_q} + {1'b0, tail_valid_q};
  assign in_ready = (count < DEPTH_C);
  assign accept   = in_valid & in_ready;
  assign push     = accept & ~type_illegal;
  assign pop      = head_valid_q & out_ready;

  assign out_valid = head_valid_q;
  assign out_word  = head_word_q;
  assign out_addr  = head_addr_q;
  assign err_type  = err_type_q;
  assign err_imm   = err_imm_q;

  // Next-state: pop first (tail slides into head), then push into the first free slot
  always_comb begin
    head_word_d  = head_word_q;
    head_addr_d  = head_addr_q;
    head_valid_d = head_valid_q;
    tail_word_d  = tail_word_q;
    tail_addr_d  = tail_addr_q;
    tail_valid_d = tail_valid_q;
    next_addr_d  = next_addr_q;
    err_type_d   = err_type_q;
    err_imm_d    = err_imm_q;

    if (pop) begin
      if (tail_valid_q) begin
        head_word_d  = tail_word_q;
        head_addr_d  = tail_addr_q;
        tail_valid_d = 1'b0;
      end else begin
        // Head data is left in place so out_word/out_addr hold when empty
        head_valid_d = 1'b0;
      end
    end

    if (push) begin
      if (!head_valid_d) begin
        head_word_d  = packed_word;
        head_addr_d  = next_addr_q;
        head_valid_d = 1'b1;
      end else begin
        tail_word_d  = packed_word;
        tail_addr_d  = next_addr_q;
        tail_valid_d = 1'b1;
      end
      next_addr_d = next_addr_q + ADDR_ONE;
      if (imm_ovf) begin
        err_imm_d = 1'b1;
      end
    end

    // Illegal bundles are swallowed without using an address
    if (accept && type_illegal) begin
      err_type_d = 1'b1;
    end
  end

  // State registers; rst and flush both return everything to the empty state
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_word_q  <= 32'd0;
      head_addr_q  <= '0;
      head_valid_q <= 1'b0;
      tail_word_q  <= 32'd0;
      tail_addr_q  <= '0;
      tail_valid_q <= 1'b0;
      next_addr_q  <= '0;
      err_type_q   <= 1'b0;
      err_imm_q    <= 1'b0;
    end else begin
      head_word_q  <= head_word_d;
      head_addr_q  <= head_addr_d;
      head_valid_q <= head_valid_d;
      tail_word_q  <= tail_word_d;
      tail_addr_q  <= tail_addr_d;
      tail_valid_q <= tail_valid_d;
      next_addr_q  <= next_addr_d;
      err_type_q   <= err_type_d;
      err_imm_q    <= err_imm_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (ADDR_W=4 to reach address wrap).
// Directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a queue-based reference model.
module tb_instr_encoder;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    opcode = 8'd0;
  logic [2:0]    instr_type = 3'd0;
  logic [3:0]    rde = 4'd0, rs1 = 4'd0, rs2 = 4'd0, func = 4'd0;
  logic [23:0]   imm = 24'd0;
  logic          in_ready, out_valid, err_type, err_imm;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;

  instr_encoder #(.ADDR_W(AW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .instr_type(instr_type),
    .rde(rde), .rs1(rs1), .rs2(rs2), .func(func), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err_type(err_type), .err_imm(err_imm)
  );

  always #5 clk = ~clk;

`ifdef ENCODER_IMM_CHECK_EN
  localparam bit IMM_CHECK = 1'b1;
`else
  localparam bit IMM_CHECK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]   w;
    logic [AW-1:0] a;
  } ent_t;

  ent_t          exp_q[$];
  int unsigned   m_naddr = 0;
  bit            m_et = 1'b0, m_ei = 1'b0;
  logic [31:0]   shown_w = 32'd0;
  logic [AW-1:0] shown_a = '0;
  bit            cmp_en = 1'b0;
  int            imm_w[8] = '{8, 12, 12, 16, 16, 20, 24, 24};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word value from the field placement rules, as plain arithmetic
  function automatic logic [31:0] model_word(input longint unsigned op, input longint unsigned t,
      input longint unsigned rd, input longint unsigned r1, input longint unsigned r2,
      input longint unsigned fn, input longint unsigned im);
    longint unsigned w;
    case (t)
      0: w = op + (im % 256) * 256 + fn * 2**16 + r2 * 2**20 + r1 * 2**24 + rd * 2**28;
      1: w = op + (im % 4096) * 256 + r2 * 2**20 + r1 * 2**24 + rd * 2**28;
      2: w = op + (im % 4096) * 256 + fn * 2**20 + r1 * 2**24 + rd * 2**28;
      3: w = op + (im % 65536) * 256 + r1 * 2**24 + rd * 2**28;
      4: w = op + (im % 65536) * 256 + fn * 2**24 + rd * 2**28;
      5: w = op + (im % 2**20) * 256 + fn * 2**28;
      6: w = op + (im % 2**24) * 256;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Reference model: advances on every rising edge from the driven inputs
  initial forever begin
    bit can_acc;
    @(posedge clk);
    if (rst || flush) begin
      exp_q.delete();
      m_naddr = 0;
      m_et = 1'b0;
      m_ei = 1'b0;
      shown_w = 32'd0;
      shown_a = '0;
    end else begin
      can_acc = (exp_q.size() < 2);
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && can_acc) begin
        if (instr_type == 3'd7) begin
          m_et = 1'b1;
        end else begin
          ent_t e;
          e.w = model_word(opcode, instr_type, rde, rs1, rs2, func, imm);
          e.a = AW'(m_naddr);
          exp_q.push_back(e);
          m_naddr = (m_naddr + 1) % (2**AW);
          if (IMM_CHECK && ((imm >> imm_w[instr_type]) != 0)) m_ei = 1'b1;
        end
      end
      if (exp_q.size() > 0) begin
        shown_w = exp_q[0].w;
        shown_a = exp_q[0].a;
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      chk("out_word", 64'(out_word), 64'(shown_w));
      chk("out_addr", 64'(out_addr), 64'(shown_a));
      chk("err_type", 64'(err_type), 64'(m_et));
      chk("err_imm", 64'(err_imm), 64'(m_ei));
    end
  end

  // Inputs change just after the falling edge, clear of both sample points
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_fields(input logic [7:0] op, input logic [2:0] t, input logic [3:0] d,
      input logic [3:0] a, input logic [3:0] b, input logic [3:0] f, input logic [23:0] i);
    opcode = op; instr_type = t; rde = d; rs1 = a; rs2 = b; func = f; imm = i;
  endtask

  // Hold the bundle until it is accepted (bounded)
  task automatic send(input logic [7:0] op, input logic [2:0] t, input logic [3:0] d,
      input logic [3:0] a, input logic [3:0] b, input logic [3:0] f, input logic [23:0] i);
    bit acc = 1'b0;
    set_fields(op, t, d, a, b, f, i);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    cmp_en = 1'b1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_word", 64'(out_word), 64'h0);
    chk("rst_out_addr", 64'(out_addr), 64'h0);
    chk("rst_err_type", 64'(err_type), 64'h0);
    chk("rst_err_imm", 64'(err_imm), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Pin the model's field placement
    chk("model_I", 64'(model_word(8'h21, 3, 3, 5, 0, 0, 24'h00BEEF)), 64'h35BEEF21);
    chk("model_B", 64'(model_word(8'h40, 5, 0, 0, 0, 4'hA, 24'h012345)), 64'hA1234540);
    chk("model_E", 64'(model_word(8'h11, 0, 1, 2, 3, 4, 24'h000100)), 64'h12340011);

    // I-type word
    out_ready = 1'b0;
    send(8'h21, 3'd3, 4'd3, 4'd5, 4'd0, 4'd0, 24'h00BEEF);
    chk("I_word", 64'(out_word), 64'h35BEEF21);
    chk("I_addr", 64'(out_addr), 64'h0);
    do_reset();

    // B then U, in order, consecutive addresses
    send(8'h40, 3'd5, 4'd0, 4'd0, 4'd0, 4'hA, 24'h012345);
    send(8'h40, 3'd6, 4'd0, 4'd0, 4'd0, 4'd0, 24'hABCDEF);
    chk("B_word", 64'(out_word), 64'hA1234540);
    chk("B_addr", 64'(out_addr), 64'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("U_word", 64'(out_word), 64'hABCDEF40);
    chk("U_addr", 64'(out_addr), 64'h1);
    do_reset();

    // Full FIFO holds off the third bundle until the sink drains
    send(8'h01, 3'd3, 4'd1, 4'd1, 4'd0, 4'd0, 24'h000001);
    send(8'h02, 3'd3, 4'd2, 4'd2, 4'd0, 4'd0, 24'h000002);
    set_fields(8'h03, 3'd3, 4'd3, 4'd3, 4'd0, 4'd0, 24'h000003);
    in_valid = 1'b1;
    tick();
    chk("full_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("full_in_ready2", 64'(in_ready), 64'h0);
    chk("full_head_addr", 64'(out_addr), 64'h0);
    out_ready = 1'b1;
    tick();
    chk("drain_addr1", 64'(out_addr), 64'h1);
    tick();
    in_valid = 1'b0;
    chk("drain_addr2", 64'(out_addr), 64'h2);
    chk("drain_word3", 64'(out_word), 64'h33000303);
    tick();
    out_ready = 1'b0;
    chk("drain_empty", 64'(out_valid), 64'h0);
    chk("drain_hold_addr", 64'(out_addr), 64'h2);
    do_reset();

    // Simultaneous push/pop at count 1
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(8'(k), 3'd6, 4'd0, 4'd0, 4'd0, 4'd0, 24'(k * 3));
      chk("stream_in_ready", 64'(in_ready), 64'h1);
      chk("stream_addr", 64'(out_addr), 64'(k % 16));
    end
    out_ready = 1'b0;
    tick();
    do_reset();

    // Illegal type: consumed, flagged, address not used
    send(8'h10, 3'd1, 4'd1, 4'd2, 4'd3, 4'd0, 24'h000ABC);
    send(8'h11, 3'd7, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0);
    send(8'h12, 3'd2, 4'd4, 4'd5, 4'd0, 4'd6, 24'h000123);
    chk("illegal_err_type", 64'(err_type), 64'h1);
    chk("illegal_head_addr", 64'(out_addr), 64'h0);
    out_ready = 1'b1;
    tick();
    chk("illegal_next_addr", 64'(out_addr), 64'h1);
    chk("illegal_next_word", 64'(out_word), 64'h45612312);
    out_ready = 1'b0;
    do_reset();

    // 17 words with a 4-bit address: the 17th wraps to 0
    out_ready = 1'b1;
    for (int k = 0; k < 17; k++) send(8'h55, 3'd6, 4'd0, 4'd0, 4'd0, 4'd0, 24'(k));
    chk("wrap_addr", 64'(out_addr), 64'h0);
    chk("wrap_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b0;
    tick();
    do_reset();

    // E-type immediate overflow, then flush clears everything
    send(8'h11, 3'd0, 4'd1, 4'd2, 4'd3, 4'd4, 24'h000100);
    chk("E_word", 64'(out_word), 64'h12340011);
    chk("E_err_imm", 64'(err_imm), 64'(IMM_CHECK));
    send(8'h00, 3'd7, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_err_type", 64'(err_type), 64'h0);
    chk("flush_err_imm", 64'(err_imm), 64'h0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 100) == 0;
      rst       = ($urandom % 250) == 0;
      opcode    = 8'($urandom);
      instr_type = 3'($urandom);
      rde = 4'($urandom); rs1 = 4'($urandom); rs2 = 4'($urandom); func = 4'($urandom);
      imm = (($urandom % 4) == 0) ? 24'($urandom) : 24'($urandom & 32'hFF);
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
